// File: rtl/adc_pkg.sv
// Shared types and constants for the multi-channel ADC capture engine.
// The optional averaging build is selected with the ADC_AVG_EN macro.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_LAT   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } adc_state_e;

  // Static converter straps
  localparam logic STRAP_CS_N   = 1'b0;
  localparam logic STRAP_REFSEL = 1'b1;
  localparam logic STRAP_SD     = 1'b0;
  localparam logic STRAP_UB     = 1'b0;
  localparam logic STRAP_SEL    = 1'b0;

  localparam int DEF_DATA_W   = 32'd12;
  localparam int DEF_CHANNELS = 32'd2;
  localparam int DEF_SCLK_DIV = 32'd4;
  localparam int DEF_LATENCY  = 32'd4;
  localparam int DEF_GAP      = 32'd1;
  localparam int DEF_AVG_LOG2 = 32'd2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Free-running SCLK divider: ADC_SCLK is a register, rise_tick/fall_tick flag
// the system clock in which it toggles 0->1 / 1->0.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic CLOCK_50MHz,
  input  logic RESET_n,
  output logic ADC_SCLK,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(SCLK_DIV);

  logic [CW-1:0] div_cnt_r;
  logic          sclk_r;
  logic          wrap_s;

  assign wrap_s    = (div_cnt_r == CW'(SCLK_DIV - 32'd1));
  assign rise_tick = wrap_s & ~sclk_r;
  assign fall_tick = wrap_s & sclk_r;
  assign ADC_SCLK  = sclk_r;

  // Half-period counter and SCLK toggle
  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      div_cnt_r <= {CW{1'b0}};
      sclk_r    <= 1'b0;
    end else if (wrap_s) begin
      div_cnt_r <= {CW{1'b0}};
      sclk_r    <= ~sclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(32'd1);
    end
  end

endmodule

// File: rtl/adc_multi_capture.sv
// Multi-channel simultaneous-sampling ADC capture engine (single-shot / continuous).
// Define ADC_AVG_EN to average 2^AVG_LOG2 frames per published result.
module adc_multi_capture
  import adc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SCLK_DIV = DEF_SCLK_DIV,
  parameter int LATENCY  = DEF_LATENCY,
  parameter int GAP      = DEF_GAP,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                       CLOCK_50MHz,
  input  logic                       RESET_n,
  input  logic                       START,
  input  logic                       CONT,
  input  logic [CHANNELS-1:0]        ADC_OUT,
  output logic                       ADC_SCLK,
  output logic                       ADC_CNVST,
  output logic                       ADC_CS_N,
  output logic                       ADC_REFSEL,
  output logic                       ADC_SD,
  output logic                       ADC_UB,
  output logic                       ADC_SEL,
  output logic                       BUSY,
  output logic [CHANNELS*DATA_W-1:0] DATA,
  output logic                       DATA_VALID,
  output logic                       OVERRUN
);

  localparam int CNT_W = $clog2(max3(LATENCY, DATA_W, GAP) + 32'd1);

  adc_state_e                      state_r, state_nx_s;
  logic [CNT_W-1:0]                cnt_r, cnt_nx_s;
  logic                            rise_tick_s, fall_tick_unused_s;
  logic                            cnvst_fall_s, shift_en_s, publish_s, keep_going_s;
  logic [CHANNELS-1:0][DATA_W-1:0] sr_r, data_r;
  logic                            cnvst_r, busy_r, valid_r, overrun_r;

  adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .CLOCK_50MHz(CLOCK_50MHz),
    .RESET_n    (RESET_n),
    .ADC_SCLK   (ADC_SCLK),
    .rise_tick  (rise_tick_s),
    .fall_tick  (fall_tick_unused_s)
  );

`ifdef ADC_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [CHANNELS-1:0][ACC_W-1:0] acc_r, sum_s;
  logic [AVG_LOG2-1:0]            grp_cnt_r;
  logic                           grp_last_s;

  assign grp_last_s   = &grp_cnt_r;
  assign publish_s    = (state_r == ST_DONE) & grp_last_s;
  // An unfinished group keeps converting even after CONT drops
  assign keep_going_s = CONT | ((state_r == ST_DONE) ? ~grp_last_s
                                                     : (grp_cnt_r != {AVG_LOG2{1'b0}}));

  // Running sum including the frame just shifted in
  always_comb begin
    sum_s = {(CHANNELS*ACC_W){1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      sum_s[k] = acc_r[k] + {{AVG_LOG2{1'b0}}, sr_r[k]};
    end
  end

  // Accumulators and frame-in-group counter
  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      acc_r     <= {(CHANNELS*ACC_W){1'b0}};
      grp_cnt_r <= {AVG_LOG2{1'b0}};
    end else if (state_r == ST_DONE) begin
      acc_r     <= grp_last_s ? {(CHANNELS*ACC_W){1'b0}} : sum_s;
      grp_cnt_r <= grp_cnt_r + AVG_LOG2'(32'd1);
    end
  end

  // Published result: truncated mean of the group
  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      data_r <= {(CHANNELS*DATA_W){1'b0}};
    end else if (publish_s) begin
      for (int k = 0; k < CHANNELS; k++) begin
        data_r[k] <= sum_s[k][ACC_W-1:AVG_LOG2];
      end
    end
  end
`else
  localparam int AVG_LOG2_UNUSED = AVG_LOG2;

  assign publish_s    = (state_r == ST_DONE);
  assign keep_going_s = CONT;

  // Published result: the frame just shifted in
  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      data_r <= {(CHANNELS*DATA_W){1'b0}};
    end else if (publish_s) begin
      data_r <= sr_r;
    end
  end
`endif

  // State and tick counter registers
  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next state; every step past IDLE advances only on SCLK rise ticks
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    cnvst_fall_s = 1'b0;
    shift_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START | CONT) state_nx_s = ST_ALIGN;
        else              state_nx_s = ST_IDLE;
      end
      ST_ALIGN: begin
        if (rise_tick_s) begin
          cnvst_fall_s = 1'b1;
          cnt_nx_s     = {CNT_W{1'b0}};
          state_nx_s   = (LATENCY == 32'd0) ? ST_SHIFT : ST_LAT;
        end else begin
          state_nx_s = ST_ALIGN;
        end
      end
      ST_LAT: begin
        if (rise_tick_s) begin
          if (cnt_r == CNT_W'(LATENCY - 32'd1)) begin
            cnt_nx_s   = {CNT_W{1'b0}};
            state_nx_s = ST_SHIFT;
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(32'd1);
          end
        end else begin
          state_nx_s = ST_LAT;
        end
      end
      ST_SHIFT: begin
        if (rise_tick_s) begin
          shift_en_s = 1'b1;
          if (cnt_r == CNT_W'(DATA_W - 32'd1)) begin
            cnt_nx_s   = {CNT_W{1'b0}};
            state_nx_s = ST_DONE;
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(32'd1);
          end
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        cnt_nx_s = {CNT_W{1'b0}};
        if (keep_going_s) state_nx_s = ST_GAP;
        else              state_nx_s = ST_IDLE;
      end
      ST_GAP: begin
        if (rise_tick_s) begin
          if (cnt_r == CNT_W'(GAP - 32'd1)) begin
            cnt_nx_s = {CNT_W{1'b0}};
            if (keep_going_s) begin
              cnvst_fall_s = 1'b1;
              state_nx_s   = (LATENCY == 32'd0) ? ST_SHIFT : ST_LAT;
            end else begin
              state_nx_s = ST_IDLE;
            end
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(32'd1);
          end
        end else begin
          state_nx_s = ST_GAP;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Converter control, strobes and deserialisers
  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      cnvst_r   <= 1'b1;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      sr_r      <= {(CHANNELS*DATA_W){1'b0}};
    end else begin
      overrun_r <= START & (state_r != ST_IDLE);
      valid_r   <= publish_s;
      if (cnvst_fall_s) begin
        cnvst_r <= 1'b0;
        busy_r  <= 1'b1;
      end else if (state_r == ST_DONE) begin
        cnvst_r <= 1'b1;
        busy_r  <= ~publish_s;
      end
      if (shift_en_s) begin
        for (int k = 0; k < CHANNELS; k++) begin
          sr_r[k] <= {sr_r[k][DATA_W-2:0], ADC_OUT[k]};
        end
      end
    end
  end

  assign ADC_CNVST  = cnvst_r;
  assign BUSY       = busy_r;
  assign DATA       = data_r;
  assign DATA_VALID = valid_r;
  assign OVERRUN    = overrun_r;
  assign ADC_CS_N   = STRAP_CS_N;
  assign ADC_REFSEL = STRAP_REFSEL;
  assign ADC_SD     = STRAP_SD;
  assign ADC_UB     = STRAP_UB;
  assign ADC_SEL    = STRAP_SEL;

endmodule

// File: tb/tb_adc_multi_capture.sv
// Directed bench for adc_multi_capture with a falling-edge-shifting ADC model.
// With ADC_AVG_EN defined the per-frame tests are replaced by the averaging test.
module tb_adc_multi_capture;

  localparam int DATA_W   = 12;
  localparam int CHANNELS = 2;
  localparam int SCLK_DIV = 4;
  localparam int LATENCY  = 4;
  localparam int GAP      = 1;
  localparam int AVG_LOG2 = 2;

  logic                       CLOCK_50MHz = 1'b0;
  logic                       RESET_n = 1'b0;
  logic                       START = 1'b0;
  logic                       CONT = 1'b0;
  logic [CHANNELS-1:0]        ADC_OUT = '0;
  logic                       ADC_SCLK, ADC_CNVST, ADC_CS_N, ADC_REFSEL, ADC_SD, ADC_UB, ADC_SEL;
  logic                       BUSY, DATA_VALID, OVERRUN;
  logic [CHANNELS*DATA_W-1:0] DATA;

  int tests_run = 0;
  int tests_failed = 0;

  logic [23:0] word_q[$];
  logic [23:0] cur_word;

  adc_multi_capture #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .SCLK_DIV(SCLK_DIV),
    .LATENCY(LATENCY), .GAP(GAP), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .CLOCK_50MHz(CLOCK_50MHz), .RESET_n(RESET_n), .START(START), .CONT(CONT),
    .ADC_OUT(ADC_OUT), .ADC_SCLK(ADC_SCLK), .ADC_CNVST(ADC_CNVST),
    .ADC_CS_N(ADC_CS_N), .ADC_REFSEL(ADC_REFSEL), .ADC_SD(ADC_SD),
    .ADC_UB(ADC_UB), .ADC_SEL(ADC_SEL), .BUSY(BUSY), .DATA(DATA),
    .DATA_VALID(DATA_VALID), .OVERRUN(OVERRUN)
  );

  always #10 CLOCK_50MHz = ~CLOCK_50MHz;

  // ADC model: after CNVST falls, LATENCY idle SCLK falls, then bits MSB first
  always begin
    @(negedge ADC_CNVST);
    if (word_q.size() > 0) cur_word = word_q.pop_front();
    else                   cur_word = 24'h0;
    for (int i = 0; i < LATENCY + DATA_W; i++) begin
      @(negedge ADC_SCLK);
      if (i >= LATENCY) begin
        ADC_OUT[0] = cur_word[DATA_W-1-(i-LATENCY)];
        ADC_OUT[1] = cur_word[2*DATA_W-1-(i-LATENCY)];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50MHz);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while (ADC_CNVST === 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid(input int max_n, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (DATA_VALID !== 1'b1 && n < max_n);
  endtask

  initial begin
    int n, m, cnt, bad;
    logic prev_cnvst;

    // Reset values
    repeat (3) tick();
    check("rst_sclk", ADC_SCLK, 1'b0);
    check("rst_cnvst", ADC_CNVST, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_data", DATA, 24'h0);
    check("rst_valid", DATA_VALID, 1'b0);
    check("rst_overrun", OVERRUN, 1'b0);
    check("straps", {ADC_CS_N, ADC_REFSEL, ADC_SD, ADC_UB, ADC_SEL}, 5'b01000);

    // Idle after release: SCLK toggles every 4 clocks, CNVST stays high
    RESET_n = 1'b1;
    bad = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check("sclk_phase", ADC_SCLK, ((e / 4) % 2) != 0);
      if (ADC_CNVST !== 1'b1) bad++;
    end
    check("idle_cnvst_high", bad, 0);

`ifndef ADC_AVG_EN
    // Single shot
    word_q.push_back({12'h3F1, 12'hA5C});
    pulse_start();
    check("start_no_overrun", OVERRUN, 1'b0);
    wait_fall(n);
    check("start_to_r0_range", (n >= 1 && n <= 2 * SCLK_DIV), 1'b1);
    check("busy_at_r0", BUSY, 1'b1);
    wait_valid(200, n);
    check("single_latency", n, 129);
    check("single_data", DATA, {12'h3F1, 12'hA5C});
    tick();
    check("single_valid_one_clk", DATA_VALID, 1'b0);
    check("single_busy_low", BUSY, 1'b0);
    check("single_data_hold", DATA, {12'h3F1, 12'hA5C});

    // Continuous, CONT dropped during frame 3
    word_q.push_back({12'h123, 12'h001});
    word_q.push_back({12'h456, 12'h7FF});
    word_q.push_back({12'h000, 12'hFFF});
    CONT = 1'b1;
    wait_valid(300, n);
    check("cont_f1_seen", DATA_VALID, 1'b1);
    check("cont_f1_data", DATA, {12'h123, 12'h001});
    wait_valid(200, n);
    check("cont_f2_period", n, 136);
    check("cont_f2_data", DATA, {12'h456, 12'h7FF});
    repeat (50) tick();
    CONT = 1'b0;
    wait_valid(200, n);
    check("cont_f3_period", n + 50, 136);
    check("cont_f3_data", DATA, {12'h000, 12'hFFF});
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ADC_CNVST !== 1'b1 || BUSY !== 1'b0 || DATA_VALID !== 1'b0) bad++;
    end
    check("cont_idle_after", bad, 0);

    // START while busy
    word_q.push_back({12'h5A5, 12'h0F0});
    pulse_start();
    wait_fall(n);
    check("ovr_r0_found", ADC_CNVST, 1'b0);
    cnt = 0;
    repeat (20) begin tick(); cnt++; end
    START = 1'b1;
    tick(); cnt++;
    check("ovr_pulse", OVERRUN, 1'b1);
    START = 1'b0;
    tick(); cnt++;
    check("ovr_one_clk", OVERRUN, 1'b0);
    wait_valid(200, n);
    check("ovr_latency", cnt + n, 129);
    check("ovr_data", DATA, {12'h5A5, 12'h0F0});
`else
    // Averaging of four frames
    word_q.push_back({12'h000, 12'd100});
    word_q.push_back({12'h000, 12'd101});
    word_q.push_back({12'h000, 12'd102});
    word_q.push_back({12'h000, 12'd104});
    pulse_start();
    wait_fall(n);
    check("avg_r0_found", ADC_CNVST, 1'b0);
    m = 1; bad = 0; cnt = 0;
    prev_cnvst = ADC_CNVST;
    while (DATA_VALID !== 1'b1 && cnt < 700) begin
      tick();
      cnt++;
      if (prev_cnvst === 1'b1 && ADC_CNVST === 1'b0) m++;
      if (BUSY !== 1'b1 && DATA_VALID !== 1'b1) bad++;
      prev_cnvst = ADC_CNVST;
    end
    check("avg_frames", m, 4);
    check("avg_latency", cnt, 3 * 136 + 129);
    check("avg_busy_held", bad, 0);
    check("avg_data", DATA, {12'h000, 12'd101});
    tick();
    check("avg_valid_one_clk", DATA_VALID, 1'b0);
    check("avg_busy_low", BUSY, 1'b0);
`endif

    // Reset during the data phase
    word_q.push_back({12'hFFF, 12'hFFF});
    pulse_start();
    wait_fall(n);
    check("rstmid_r0_found", ADC_CNVST, 1'b0);
    repeat ((LATENCY + 6) * 2 * SCLK_DIV) tick();
    check("rstmid_busy_before", BUSY, 1'b1);
    RESET_n = 1'b0;
    #1;
    check("rstmid_cnvst", ADC_CNVST, 1'b1);
    check("rstmid_busy", BUSY, 1'b0);
    check("rstmid_data", DATA, 24'h0);
    repeat (2) tick();
    RESET_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (DATA_VALID !== 1'b0 || ADC_CNVST !== 1'b1) bad++;
    end
    check("rstmid_no_valid", bad, 0);
    check("rstmid_data_kept", DATA, 24'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adc_multi_capture.md
# adc_multi_capture

Parametrised multi-channel capture engine for MAX1379-class simultaneous-sampling serial ADCs. It generates SCLK and CNVST from the 50 MHz system clock, deserialises one MSB-first word per channel per frame, and publishes all channels together with a one-clock valid strobe. It supports single-shot and continuous modes and overrun flagging. It replaces the fixed 2×12-bit reader, and the game/input logic downstream consumes its output.

## Interface
- DATA_W, 12: bits per sample
- CHANNELS, 2: number of serial data lines (≥1)
- SCLK_DIV, 4: system clocks per SCLK half-period (≥2); SCLK = 50 MHz/(2·SCLK_DIV)
- LATENCY, 4: SCLK rising edges between CNVST fall and the first data bit
- GAP, 1: SCLK rising edges that CNVST stays high between continuous frames (≥1)
- AVG_LOG2, 2: log2 of frames averaged (used only with ADC_AVG_EN)

- CLOCK_50MHz  in  1  system clock; all logic is on its rising edge
- RESET_n  in  1  asynchronous, active-low reset
- START  in  1  one-clock pulse that requests a single frame
- CONT  in  1  level; while high, frames repeat back-to-back
- ADC_OUT  in  CHANNELS  serial data, one line per channel
- ADC_SCLK  out  1  serial clock (register, not a derived clock)
- ADC_CNVST  out  1  conversion start, active-low
- ADC_CS_N, ADC_REFSEL, ADC_SD, ADC_UB, ADC_SEL  out  1 each  static straps: 0, 1, 0, 0, 0
- BUSY  out  1  high from CNVST fall to DONE
- DATA  out  CHANNELS·DATA_W  channel k occupies [k·DATA_W +: DATA_W]
- DATA_VALID  out  1  one-clock strobe; DATA is new
- OVERRUN  out  1  one-clock strobe; START was rejected

## Operation
- Reset values: ADC_SCLK=0, ADC_CNVST=1, BUSY=0, DATA=0, DATA_VALID=0, OVERRUN=0, state IDLE, divider cleared.
- Rise tick: the clock in which the divider wraps and ADC_SCLK goes 0→1. ADC_OUT is sampled on rise ticks only.
- States:
  - IDLE: START=1 or CONT=1 → ALIGN.
  - ALIGN: at the next rise tick (R0), CNVST←0, BUSY←1 → LAT.
  - LAT: counts LATENCY rise ticks (R1..R_LATENCY) → SHIFT.
  - SHIFT: DATA_W rise ticks. Each tick shifts ADC_OUT[k] into shift register k, MSB first.
  - DONE (one clock): publish DATA, DATA_VALID←1, CNVST←1, BUSY←0. CONT=1 → GAP, otherwise IDLE.
  - GAP: CNVST falls at the GAP-th rise tick after DONE → LAT. If CONT=0 at that tick → IDLE with no fall.
- START in any state other than IDLE: ignored, OVERRUN pulses one clock. START and CONT together in IDLE start one frame only.
- CONT falling mid-frame: the current frame completes and publishes, then IDLE.
- Reset mid-frame: the frame is aborted, DATA keeps 0, and no DATA_VALID is produced.
- DATA holds its value between DATA_VALID strobes.

## Timing
- SCLK period is 2·SCLK_DIV clocks (8 by default, 6.25 MHz); SCLK high and low are each SCLK_DIV clocks.
- With defaults: R0 = CNVST fall, R1–R4 = latency, R5–R16 = bits 11..0. DATA_VALID asserts in the clock after R16, 129 clocks after R0.
- Continuous frame period: (LATENCY+DATA_W+GAP) rise ticks = 136 clocks by default.
- START→R0 takes 1 to 2·SCLK_DIV clocks, depending on divider phase.

## Configuration
- ADC_AVG_EN defined: per-channel accumulators of width DATA_W+AVG_LOG2 sum 2^AVG_LOG2 frames.
  - DATA = sum >> AVG_LOG2 (truncating). DATA_VALID pulses only on the last frame of each group.
  - BUSY stays high across the whole group; DONE publishes only at group end.
  - CONT dropping mid-group finishes the group.
  - Reset clears accumulators and the group counter.
- ADC_AVG_EN undefined: every frame publishes directly. AVG_LOG2 is ignored and no accumulator logic is built.

## Structure
- Package adc_pkg holds: the state enum (IDLE, ALIGN, LAT, SHIFT, DONE, GAP), the static strap constants, and the default parameter constants.
- Sub-module adc_sclk_gen takes SCLK_DIV and produces ADC_SCLK plus rise_tick/fall_tick enables. It resets asynchronously on RESET_n.

## Test plan
- Reset → all outputs at reset values; after release with START=0, CNVST stays 1 and SCLK toggles every 4 clocks.
- START pulse, ADC model drives 0xA5C on ch0 and 0x3F1 on ch1 → one DATA_VALID 129 clocks after the CNVST fall, DATA = {0x3F1, 0xA5C}, BUSY low afterward.
- CONT=1 for 3 frames with values 0x001, 0x7FF, 0xFFF → three DATA_VALID strobes 136 clocks apart, then IDLE after CONT drops mid-frame 3 with frame 3 still published.
- START pulse while BUSY → OVERRUN single-clock pulse, frame timing unchanged.
- RESET_n low at bit 6 of a frame → CNVST=1 and BUSY=0 immediately, no DATA_VALID, DATA=0.
- ADC_AVG_EN, AVG_LOG2=2, ch0 samples 100, 101, 102, 104 → single DATA_VALID with ch0 = 101 (407>>2).
